segment_transition_ctrl: RTL and testbench

SEGMENT_TRANSITION_CTRL -- requirements
Module: segment_transition_ctrl

---
 rtl/segment_transition_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_segment_transition_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_transition_ctrl.sv
// Segment index sequencer with request/trigger driven segment switching.
// Optional feature: define SEGMENT_TRANSITION_GPIO_EN for the GPIO trigger mode and its synchronisers.
module segment_transition_ctrl #(
    parameter int  NUM_SEGMENT = 2,
    parameter int  IDX_WIDTH   = 16,
    parameter int  REP_WIDTH   = 16,
    localparam int SEG_W       = (NUM_SEGMENT > 1) ? $clog2(NUM_SEGMENT) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             update_i,
    input  logic [63:0]                      sys_time_i,
    input  logic [3:0]                       gpio_in_i,
    input  logic                             req_valid_i,
    input  logic [SEG_W-1:0]                 req_segment_i,
    input  logic [7:0]                       req_mode_i,
    input  logic [63:0]                      req_value_i,
    input  logic [NUM_SEGMENT*IDX_WIDTH-1:0] cycle_i,
    input  logic [NUM_SEGMENT*REP_WIDTH-1:0] rep_i,
    output logic [SEG_W-1:0]                 segment_o,
    output logic [IDX_WIDTH-1:0]             idx_o,
    output logic                             stop_o,
    output logic                             pending_o,
    output logic                             req_err_o
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;

    localparam logic [7:0] MODE_SYNC = 8'h00;
    localparam logic [7:0] MODE_TIME = 8'h01;
    localparam logic [7:0] MODE_GPIO = 8'h02;
    localparam logic [7:0] MODE_EXT  = 8'hF0;

    logic [1:0]           state_q, state_d;
    logic [SEG_W-1:0]     seg_q, seg_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [REP_WIDTH-1:0] loop_q, loop_d;
    logic                 stop_q, stop_d;
    logic                 pending_q, pending_d;
    logic                 err_q, err_d;
    logic                 ext_q, ext_d;
    logic [SEG_W-1:0]     lat_seg_q, lat_seg_d;
    logic [7:0]           lat_mode_q, lat_mode_d;
    logic [63:0]          lat_value_q, lat_value_d;

    logic [IDX_WIDTH-1:0] cur_cycle;
    logic [REP_WIDTH-1:0] cur_rep;
    logic [SEG_W-1:0]     next_seg;
    logic                 at_last, last_loop, trig, fire, accept;
    logic                 gpio_trig, gpio_mode_ok;

    assign cur_cycle = cycle_i[int'(seg_q) * IDX_WIDTH +: IDX_WIDTH];
    assign cur_rep   = rep_i[int'(seg_q) * REP_WIDTH +: REP_WIDTH];
    assign next_seg  = (int'(seg_q) == NUM_SEGMENT - 1) ? '0 : seg_q + 1'b1;
    assign at_last   = (idx_q == cur_cycle);
    assign last_loop = !(&cur_rep) && (loop_q == cur_rep);

`ifdef SEGMENT_TRANSITION_GPIO_EN
    logic [3:0] sync1_q, sync2_q, sync3_q, rise_q;

    // Two synchroniser flops, an edge-detect flop and a registered rising-edge pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            rise_q  <= '0;
        end else begin
            sync1_q <= gpio_in_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            rise_q  <= sync2_q & ~sync3_q;
        end
    end

    assign gpio_trig    = rise_q[lat_value_q[1:0]];
    assign gpio_mode_ok = 1'b1;
`else
    logic gpio_unused;
    assign gpio_unused  = ^gpio_in_i;
    assign gpio_trig    = 1'b0;
    assign gpio_mode_ok = 1'b0;
`endif

    always_comb begin
        trig = 1'b0;
        case (lat_mode_q)
            MODE_SYNC: trig = update_i && (stop_q || at_last);
            MODE_TIME: trig = (sys_time_i >= lat_value_q);
            MODE_GPIO: trig = gpio_trig;
            MODE_EXT:  trig = 1'b1;
            default:   trig = 1'b0;
        endcase
    end

    assign fire   = (state_q == ST_WAIT) && trig;
    assign accept = req_valid_i && (int'(req_segment_i) < NUM_SEGMENT) &&
                    ((req_mode_i == MODE_SYNC) || (req_mode_i == MODE_TIME) ||
                     (req_mode_i == MODE_EXT) || (gpio_mode_ok && (req_mode_i == MODE_GPIO)));

    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        idx_d       = idx_q;
        loop_d      = loop_q;
        stop_d      = stop_q;
        pending_d   = pending_q;
        ext_d       = ext_q;
        lat_seg_d   = lat_seg_q;
        lat_mode_d  = lat_mode_q;
        lat_value_d = lat_value_q;
        err_d       = req_valid_i && !accept;

        if (update_i && !stop_q) begin
            if (!at_last) begin
                idx_d = idx_q + 1'b1;
            end else if (last_loop) begin
                // Auto-sequencing replaces the stop with a hop to the next segment.
                if (ext_q) begin
                    seg_d  = next_seg;
                    idx_d  = '0;
                    loop_d = '0;
                end else begin
                    stop_d = 1'b1;
                end
            end else begin
                idx_d  = '0;
                loop_d = loop_q + 1'b1;
            end
        end

        if (fire) begin
            state_d   = ST_SWITCH;
            seg_d     = lat_seg_q;
            idx_d     = '0;
            loop_d    = '0;
            stop_d    = 1'b0;
            pending_d = 1'b0;
            if (lat_mode_q == MODE_EXT) begin
                ext_d = 1'b1;
            end
        end else if (state_q == ST_SWITCH) begin
            state_d = pending_q ? ST_WAIT : ST_RUN;
        end

        // Latching happens after the trigger so a same-cycle request waits for the next one.
        if (accept) begin
            lat_seg_d   = req_segment_i;
            lat_mode_d  = req_mode_i;
            lat_value_d = req_value_i;
            pending_d   = 1'b1;
            if (req_mode_i != MODE_EXT) begin
                ext_d = 1'b0;
            end
            if (!fire) begin
                state_d = ST_WAIT;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            seg_q       <= '0;
            idx_q       <= '0;
            loop_q      <= '0;
            stop_q      <= 1'b0;
            pending_q   <= 1'b0;
            err_q       <= 1'b0;
            ext_q       <= 1'b0;
            lat_seg_q   <= '0;
            lat_mode_q  <= MODE_SYNC;
            lat_value_q <= '0;
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_d;
            idx_q       <= idx_d;
            loop_q      <= loop_d;
            stop_q      <= stop_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
            ext_q       <= ext_d;
            lat_seg_q   <= lat_seg_d;
            lat_mode_q  <= lat_mode_d;
            lat_value_q <= lat_value_d;
        end
    end

    assign segment_o = seg_q;
    assign idx_o     = idx_q;
    assign stop_o    = stop_q;
    assign pending_o = pending_q;
    assign req_err_o = err_q;

endmodule

// File: tb/tb_segment_transition_ctrl.sv
// Bench for segment_transition_ctrl: directed vectors plus randomized traffic against a reference model.
module tb_segment_transition_ctrl;

    localparam int NSEG    = 3;
    localparam int IW      = 8;
    localparam int RW      = 4;
    localparam int REP_INF = 15;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              update_i;
    logic [63:0]       sys_time_i;
    logic [3:0]        gpio_in_i;
    logic              req_valid_i;
    logic [1:0]        req_segment_i;
    logic [7:0]        req_mode_i;
    logic [63:0]       req_value_i;
    logic [NSEG*IW-1:0] cycle_i;
    logic [NSEG*RW-1:0] rep_i;
    logic [1:0]        segment_o;
    logic [IW-1:0]     idx_o;
    logic              stop_o;
    logic              pending_o;
    logic              req_err_o;

    segment_transition_ctrl #(
        .NUM_SEGMENT(NSEG),
        .IDX_WIDTH  (IW),
        .REP_WIDTH  (RW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .update_i     (update_i),
        .sys_time_i   (sys_time_i),
        .gpio_in_i    (gpio_in_i),
        .req_valid_i  (req_valid_i),
        .req_segment_i(req_segment_i),
        .req_mode_i   (req_mode_i),
        .req_value_i  (req_value_i),
        .cycle_i      (cycle_i),
        .rep_i        (rep_i),
        .segment_o    (segment_o),
        .idx_o        (idx_o),
        .stop_o       (stop_o),
        .pending_o    (pending_o),
        .req_err_o    (req_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec  = 0;
    int n_miss = 0;

    int cyc [NSEG];
    int rep [NSEG];

    // Reference model state, in terms of the externally visible behaviour.
    int          m_seg, m_idx, m_loops, m_lseg;
    bit          m_stop, m_pend, m_err, m_ext, m_just_sw;
    logic [7:0]  m_lmode;
    logic [63:0] m_lval;
    logic [3:0]  g [5];

    typedef struct {
        logic       upd;
        logic [7:0] idx;
        logic       stop;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mode_ok(input logic [7:0] m);
`ifdef SEGMENT_TRANSITION_GPIO_EN
        return (m == 8'h00) || (m == 8'h01) || (m == 8'h02) || (m == 8'hF0);
`else
        return (m == 8'h00) || (m == 8'h01) || (m == 8'hF0);
`endif
    endfunction

    task automatic model_reset();
        m_seg = 0; m_idx = 0; m_loops = 0; m_lseg = 0;
        m_stop = 0; m_pend = 0; m_err = 0; m_ext = 0; m_just_sw = 0;
        m_lmode = 8'h00; m_lval = '0;
        for (int k = 0; k < 5; k++) g[k] = '0;
    endtask

    task automatic model_step();
        int n_seg, n_idx, n_loops;
        bit n_stop, n_pend, n_ext, fire, ok;
        for (int k = 4; k > 0; k--) g[k] = g[k-1];
        g[0] = gpio_in_i;
        n_seg = m_seg; n_idx = m_idx; n_loops = m_loops;
        n_stop = m_stop; n_pend = m_pend; n_ext = m_ext;
        fire = 0;
        if (m_pend && !m_just_sw) begin
            if (m_lmode == 8'h00)      fire = update_i && (m_stop || m_idx >= cyc[m_seg]);
            else if (m_lmode == 8'h01) fire = (sys_time_i >= m_lval);
`ifdef SEGMENT_TRANSITION_GPIO_EN
            else if (m_lmode == 8'h02) fire = g[3][m_lval[1:0]] && !g[4][m_lval[1:0]];
`endif
            else if (m_lmode == 8'hF0) fire = 1;
        end
        if (update_i && !m_stop) begin
            if (m_idx < cyc[m_seg]) begin
                n_idx = m_idx + 1;
            end else if (rep[m_seg] != REP_INF && m_loops == rep[m_seg]) begin
                if (m_ext) begin
                    n_seg = (m_seg + 1) % NSEG; n_idx = 0; n_loops = 0;
                end else begin
                    n_stop = 1;
                end
            end else begin
                n_idx = 0; n_loops = m_loops + 1;
            end
        end
        if (fire) begin
            n_seg = m_lseg; n_idx = 0; n_loops = 0; n_stop = 0; n_pend = 0;
            if (m_lmode == 8'hF0) n_ext = 1;
        end
        ok = req_valid_i && (int'(req_segment_i) < NSEG) && mode_ok(req_mode_i);
        if (ok) begin
            m_lseg = int'(req_segment_i); m_lmode = req_mode_i; m_lval = req_value_i;
            n_pend = 1;
            if (req_mode_i != 8'hF0) n_ext = 0;
        end
        m_err = req_valid_i && !ok;
        m_seg = n_seg; m_idx = n_idx; m_loops = n_loops;
        m_stop = n_stop; m_pend = n_pend; m_ext = n_ext; m_just_sw = fire;
    endtask

    task automatic compare_model();
        chk("model_seg", segment_o, m_seg);
        chk("model_idx", idx_o, m_idx);
        chk("model_stop", stop_o, m_stop);
        chk("model_pending", pending_o, m_pend);
        chk("model_req_err", req_err_o, m_err);
    endtask

    task automatic apply_cfg();
        for (int k = 0; k < NSEG; k++) begin
            cycle_i[k*IW +: IW] = IW'(cyc[k]);
            rep_i[k*RW +: RW]   = RW'(rep[k]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1; update_i = 1'b0; req_valid_i = 1'b0;
        apply_cfg();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        compare_model();
        req_valid_i = 1'b0;
        update_i    = 1'b0;
    endtask

    task automatic set_req(input int seg, input logic [7:0] mode, input logic [63:0] val);
        req_valid_i   = 1'b1;
        req_segment_i = 2'(seg);
        req_mode_i    = mode;
        req_value_i   = val;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; update_i = 1'b0; sys_time_i = '0; gpio_in_i = '0;
        req_valid_i = 1'b0; req_segment_i = '0; req_mode_i = '0; req_value_i = '0;
        cycle_i = '0; rep_i = '0;

        // Basic count-and-stop vectors: CYCLE0=3, REP0=1.
        tbl[0]  = '{1'b1, 8'd1, 1'b0};  tbl[1]  = '{1'b1, 8'd2, 1'b0};
        tbl[2]  = '{1'b0, 8'd2, 1'b0};  tbl[3]  = '{1'b1, 8'd3, 1'b0};
        tbl[4]  = '{1'b1, 8'd0, 1'b0};  tbl[5]  = '{1'b1, 8'd1, 1'b0};
        tbl[6]  = '{1'b1, 8'd2, 1'b0};  tbl[7]  = '{1'b1, 8'd3, 1'b0};
        tbl[8]  = '{1'b1, 8'd3, 1'b1};  tbl[9]  = '{1'b1, 8'd3, 1'b1};
        tbl[10] = '{1'b0, 8'd3, 1'b1};  tbl[11] = '{1'b1, 8'd3, 1'b1};

        cyc = '{3, 5, 2}; rep = '{1, REP_INF, REP_INF};
        do_reset();
        chk("reset_seg", segment_o, 0);
        chk("reset_idx", idx_o, 0);
        chk("reset_stop", stop_o, 0);
        chk("reset_pending", pending_o, 0);
        chk("reset_req_err", req_err_o, 0);
        for (int i = 0; i < 12; i++) begin
            update_i = tbl[i].upd;
            tick();
            chk("count_idx", idx_o, tbl[i].idx);
            chk("count_stop", stop_o, tbl[i].stop);
        end
        $display("seq count/stop: %0d vectors", n_vec);

        // SYNC_IDX switch on the wrapping UPDATE.
        cyc = '{3, 5, 2}; rep = '{REP_INF, REP_INF, REP_INF};
        do_reset();
        update_i = 1'b1; tick();
        set_req(1, 8'h00, 64'd0); tick();
        chk("sync_pending", pending_o, 1);
        chk("sync_idx_hold", idx_o, 1);
        update_i = 1'b1; tick();
        update_i = 1'b1; tick();
        chk("sync_before_wrap", segment_o, 0);
        update_i = 1'b1; tick();
        chk("sync_seg", segment_o, 1);
        chk("sync_idx0", idx_o, 0);
        chk("sync_pending_clr", pending_o, 0);
        $display("seq sync_idx: %0d vectors", n_vec);

        // SYS_TIME target reached while ramping.
        do_reset();
        for (int t = 990; t <= 1001; t++) begin
            sys_time_i = 64'(t);
            if (t == 990) set_req(2, 8'h01, 64'd1000);
            tick();
            chk("time_seg", segment_o, (t >= 1000) ? 2 : 0);
            chk("time_pending", pending_o, (t >= 1000) ? 0 : 1);
        end
        sys_time_i = '0;
        $display("seq sys_time: %0d vectors", n_vec);

        // GPIO trigger, or rejection when the mode is not built in.
        do_reset();
        set_req(1, 8'h02, 64'd2); tick();
`ifdef SEGMENT_TRANSITION_GPIO_EN
        chk("gpio_pending", pending_o, 1);
        gpio_in_i = 4'b0010; tick(); tick();
        gpio_in_i = 4'b0000;
        for (int i = 0; i < 5; i++) tick();
        chk("gpio_wrong_pin", segment_o, 0);
        gpio_in_i = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("gpio_latency", segment_o, (i >= 3) ? 1 : 0);
        end
        gpio_in_i = 4'b0000;
`else
        chk("gpio_req_err", req_err_o, 1);
        chk("gpio_no_pending", pending_o, 0);
        tick();
        chk("gpio_err_pulse", req_err_o, 0);
`endif
        $display("seq gpio: %0d vectors", n_vec);

        // EXT auto-sequencing through all segments.
        cyc = '{1, 1, 1}; rep = '{0, 0, 0};
        do_reset();
        set_req(0, 8'hF0, 64'd0); tick();
        chk("ext_pending", pending_o, 1);
        tick();
        chk("ext_applied", pending_o, 0);
        for (int n = 1; n <= 8; n++) begin
            update_i = 1'b1; tick();
            chk("ext_seg", segment_o, (n / 2) % 3);
            chk("ext_idx", idx_o, n % 2);
            chk("ext_stop", stop_o, 0);
        end
        $display("seq ext: %0d vectors", n_vec);

        // Request arriving in the trigger cycle waits for its own trigger.
        cyc = '{1, 2, 2}; rep = '{REP_INF, REP_INF, REP_INF};
        do_reset();
        set_req(1, 8'h00, 64'd0); tick();
        update_i = 1'b1; tick();
        update_i = 1'b1; set_req(2, 8'h01, 64'd0); tick();
        chk("overlap_seg1", segment_o, 1);
        chk("overlap_pending", pending_o, 1);
        tick();
        chk("overlap_switch_cycle", segment_o, 1);
        tick();
        chk("overlap_seg2", segment_o, 2);
        chk("overlap_pending_clr", pending_o, 0);
        $display("seq overlap: %0d vectors", n_vec);

        // Rejections and reset during WAIT.
        do_reset();
        set_req(1, 8'h05, 64'd0); tick();
        chk("bad_mode_err", req_err_o, 1);
        chk("bad_mode_pending", pending_o, 0);
        tick();
        chk("err_one_cycle", req_err_o, 0);
        set_req(3, 8'h00, 64'd0); tick();
        chk("bad_seg_err", req_err_o, 1);
        set_req(1, 8'h01, 64'd0); tick(); tick();
        chk("pre_rst_seg", segment_o, 1);
        set_req(2, 8'h01, 64'hFFFF_FFFF_FFFF_FFFF); tick();
        set_req(0, 8'h05, 64'd0); tick();
        chk("reject_keeps_pending", pending_o, 1);
        rst_i = 1'b1;
        #1;
        chk("rst_wait_pending", pending_o, 0);
        chk("rst_wait_seg", segment_o, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            update_i = 1'b1; tick();
            chk("post_rst_seg", segment_o, 0);
            chk("post_rst_pending", pending_o, 0);
        end
        $display("seq reject/reset: %0d vectors", n_vec);

        // Randomized traffic against the model.
        for (int ep = 0; ep < 6; ep++) begin
            for (int k = 0; k < NSEG; k++) begin
                cyc[k] = int'($urandom_range(0, 4));
                case ($urandom_range(0, 3))
                    0: rep[k] = 0;
                    1: rep[k] = 1;
                    2: rep[k] = 2;
                    default: rep[k] = REP_INF;
                endcase
            end
            do_reset();
            for (int c = 0; c < 400; c++) begin
                sys_time_i = sys_time_i + 64'd1;
                update_i   = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) gpio_in_i[$urandom_range(0, 3)] ^= 1'b1;
                if ($urandom_range(0, 11) == 0) begin
                    logic [7:0] md;
                    case ($urandom_range(0, 4))
                        0: md = 8'h00;
                        1: md = 8'h01;
                        2: md = 8'h02;
                        3: md = 8'hF0;
                        default: md = 8'h05;
                    endcase
                    set_req(int'($urandom_range(0, 3)), md,
                            (md == 8'h01) ? sys_time_i + 64'($urandom_range(0, 30))
                                          : 64'($urandom_range(0, 3)));
                end
                tick();
            end
            $display("random epoch %0d: %0d vectors", ep, n_vec);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
